// File: rtl/hci_mem_responder_pkg.sv
// Shared response record and parameter checks for the HCI memory responder.
// The record is sized for the widest supported data/id/user; narrower instances zero-extend into it.
package hci_package;

  localparam int HCI_DW      = 32;
  localparam int HCI_IW      = 8;
  localparam int HCI_UW      = 1;
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 4;

  typedef struct packed {
    logic              valid;
    logic [HCI_DW-1:0] data;
    logic [HCI_IW-1:0] id;
    logic [HCI_UW-1:0] user;
  } hci_rsp_t;

  function automatic bit latency_ok(input int lat);
    return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
  endfunction

endpackage

// File: rtl/hci_mem_responder_resp_pipe.sv
// Response delay line: STAGES registers behind the memory read register.
// Valid bits are reset and flushed; payload is plain data and is never reset.
module hci_mem_resp_pipe
  import hci_package::*;
#(
  parameter int STAGES = 0
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     clear_i,
  input  hci_rsp_t rsp_i,
  output hci_rsp_t rsp_o
);

  if (STAGES == 0) begin : g_bypass
    assign rsp_o = rsp_i;
  end else begin : g_chain
    logic [STAGES-1:0] vld_q;
    hci_rsp_t          pay_q [STAGES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q <= '0;
      end else if (clear_i) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= rsp_i.valid;
        for (int s = 1; s < STAGES; s++) vld_q[s] <= vld_q[s-1];
      end
    end

    always_ff @(posedge clk_i) begin
      pay_q[0] <= rsp_i;
      for (int s = 1; s < STAGES; s++) pay_q[s] <= pay_q[s-1];
    end

    always_comb begin
      rsp_o       = pay_q[STAGES-1];
      rsp_o.valid = vld_q[STAGES-1];
    end
  end

endmodule

// File: rtl/hci_mem_responder.sv
// Single-port byte-enabled TCDM memory slave with fixed response latency,
// optional grant throttling and a synchronous pipeline flush.
module hci_mem_responder
  import hci_package::*;
#(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int BW         = 8,
  parameter int IW         = 8,
  parameter int UW         = 1,
  parameter int NB_WORDS   = 1024,
  parameter int LATENCY    = 1,
  parameter int GNT_PERIOD = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             tcdm_req,
  output logic             tcdm_gnt,
  input  logic [AW-1:0]    tcdm_add,
  input  logic             tcdm_wen,
  input  logic [DW-1:0]    tcdm_data,
  input  logic [DW/BW-1:0] tcdm_be,
  input  logic [IW-1:0]    tcdm_id,
  input  logic [UW-1:0]    tcdm_user,
  output logic             tcdm_r_valid,
  output logic [DW-1:0]    tcdm_r_data,
  output logic [IW-1:0]    tcdm_r_id,
  output logic [UW-1:0]    tcdm_r_user
);

  localparam int NLANES = DW / BW;
  localparam int OFF_W  = $clog2(DW / 8);
  localparam int IDX_W  = $clog2(NB_WORDS);
  localparam int CNT_W  = (GNT_PERIOD > 1) ? $clog2(GNT_PERIOD) : 1;

  if (!latency_ok(LATENCY)) begin : g_bad_latency
    $error("hci_mem_responder: LATENCY out of range");
  end
  if (DW > HCI_DW || IW > HCI_IW || UW > HCI_UW) begin : g_bad_width
    $error("hci_mem_responder: width exceeds hci_rsp_t field");
  end

  logic [CNT_W-1:0] cnt;
  logic             cnt_wrap;
  logic             thr_open;
  logic             hs_p0;
  logic [IDX_W-1:0] idx_p0;
  logic             addr_unused;

  // Throttle: free-running phase counter, grants only at phase 0.
  assign cnt_wrap = (GNT_PERIOD <= 1) || (cnt == CNT_W'(GNT_PERIOD - 1));
  assign thr_open = (GNT_PERIOD == 0) || (cnt == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                cnt <= '0;
    else if (clear_i || cnt_wrap) cnt <= '0;
    else                        cnt <= cnt + CNT_W'(1);
  end

  assign tcdm_gnt    = tcdm_req & rst_ni & ~clear_i & thr_open;
  assign hs_p0       = tcdm_req & tcdm_gnt;
  assign idx_p0      = tcdm_add[OFF_W +: IDX_W];
  assign addr_unused = ^tcdm_add;

  // Stage p0 -> p1: memory access and request sideband capture.
  logic [DW-1:0] mem [NB_WORDS];
  logic [DW-1:0] rd_data_p1;
  logic          vld_p1;
  logic          is_rd_p1;
  logic [IW-1:0] id_p1;
  logic [UW-1:0] user_p1;

  always_ff @(posedge clk_i) begin
    if (hs_p0) begin
      if (tcdm_wen) begin
        rd_data_p1 <= mem[idx_p0];
      end else begin
        for (int i = 0; i < NLANES; i++)
          if (tcdm_be[i]) mem[idx_p0][i*BW +: BW] <= tcdm_data[i*BW +: BW];
      end
      is_rd_p1 <= tcdm_wen;
      id_p1    <= tcdm_id;
      user_p1  <= tcdm_user;
    end
  end

  // A clear forces gnt low, so the read register empties on its own.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) vld_p1 <= 1'b0;
    else         vld_p1 <= hs_p0;
  end

  hci_rsp_t rsp_p1;
  hci_rsp_t rsp_pn;

  always_comb begin
    rsp_p1       = '0;
    rsp_p1.valid = vld_p1;
    rsp_p1.data  = HCI_DW'(is_rd_p1 ? rd_data_p1 : '0);
    rsp_p1.id    = HCI_IW'(id_p1);
    rsp_p1.user  = HCI_UW'(user_p1);
  end

  // Stage p1 -> pN: remaining LATENCY-1 delay stages.
  hci_mem_resp_pipe #(
    .STAGES (LATENCY - 1)
  ) u_resp_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .rsp_i   (rsp_p1),
    .rsp_o   (rsp_pn)
  );

  assign tcdm_r_valid = rsp_pn.valid;
  assign tcdm_r_data  = rsp_pn.valid ? rsp_pn.data[DW-1:0] : '0;
  assign tcdm_r_id    = rsp_pn.valid ? rsp_pn.id[IW-1:0]   : '0;
  assign tcdm_r_user  = rsp_pn.valid ? rsp_pn.user[UW-1:0] : '0;

endmodule

// File: doc/hci_mem_responder.md
HCI_MEM_RESPONDER -- requirements
Module: hci_mem_responder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DW  32  data width, multiple of 8
  AW  32  address width, byte address
  BW  8  bits per byte-enable lane
  IW  8  request/response id width
  UW  1  user sideband width
  NB_WORDS  1024  memory depth in DW-wide words, power of two
  LATENCY  1  grant-to-response cycles, 1..4
  GNT_PERIOD  0  0 = grant every cycle; N>0 = grant only when throttle counter is 0
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk_i  in  1  clock
  rst_ni  in  1  asynchronous active-low reset
  clear_i  in  1  synchronous flush of the pipeline and throttle counter; memory contents kept
  tcdm_req  in  1  request valid
  tcdm_gnt  out  1  request accepted this cycle
  tcdm_add  in  AW  byte address
  tcdm_wen  in  1  1 = read, 0 = write
  tcdm_data  in  DW  write data
  tcdm_be  in  DW/BW  byte enables
  tcdm_id  in  IW  request id
  tcdm_user  in  UW  request user
  tcdm_r_valid  out  1  response valid
  tcdm_r_data  out  DW  read data
  tcdm_r_id  out  IW  echoed id
  tcdm_r_user  out  UW  echoed user
REQ-003 The block SHALL use one clock, clk_i; reset rst_ni SHALL be asynchronous and active-low.

Function
REQ-004 A handshake SHALL occur in a cycle where tcdm_req=1 and tcdm_gnt=1.
REQ-005 tcdm_gnt SHALL be combinational from tcdm_req and the throttle state: tcdm_gnt = tcdm_req when GNT_PERIOD=0. Otherwise tcdm_gnt = tcdm_req AND (cnt==0).
REQ-006 The throttle counter cnt SHALL be 0..GNT_PERIOD-1. It SHALL increment every cycle and wrap to 0 after GNT_PERIOD-1, independent of tcdm_req.
REQ-007 The word index SHALL be tcdm_add[log2(DW/8) +: log2(NB_WORDS)]. Upper bits SHALL be ignored, so out-of-range addresses alias with wrap-around.
REQ-008 A write handshake SHALL update only the lanes with tcdm_be set, at the clock edge ending the handshake cycle.
REQ-009 Each handshake SHALL produce exactly one response, with tcdm_r_valid=1 for exactly one cycle, exactly LATENCY cycles after the handshake cycle.
REQ-010 Responses SHALL be returned in order, and one handshake per cycle SHALL be sustainable with no back-pressure on the response side.
REQ-011 tcdm_r_id and tcdm_r_user SHALL equal the tcdm_id and tcdm_user of the matching request.
REQ-012 The read response tcdm_r_data SHALL hold the word as stored before any write accepted in the same cycle. A read one or more cycles after a write to the same word SHALL return the written data.
REQ-013 The write response SHALL drive tcdm_r_data = 0.
REQ-014 When tcdm_r_valid=0, tcdm_r_data, tcdm_r_id and tcdm_r_user SHALL be 0.
REQ-015 clear_i=1 SHALL have the following effects:
  - drop all in-flight responses, with no r_valid in later cycles for pre-clear handshakes;
  - reset cnt to 0;
  - force tcdm_gnt=0 in that cycle.

Reset
REQ-016 During reset, all of the following SHALL be 0: tcdm_gnt, tcdm_r_valid, tcdm_r_data, tcdm_r_id, tcdm_r_user, cnt, and all pipeline valid bits.
REQ-017 Reset asserted mid-operation SHALL discard in-flight responses immediately.
REQ-018 Memory contents SHALL NOT be reset.
REQ-019 The first grant after reset deassertion SHALL be possible in the first cycle, because cnt=0.

Structure
REQ-020 The response record typedef (valid, data, id, user) SHALL be defined in hci_package.
REQ-021 The LATENCY range check SHALL be defined in hci_package.
REQ-022 The response delay line SHALL be a sub-module, hci_mem_resp_pipe: a LATENCY-1 stage register chain behind the memory read register, with synchronous clear.
REQ-023 The memory array SHALL be inferred as a one-port, byte-enabled RAM.

Verification
REQ-024 Write/read test: write 0xDEADBEEF at 0x10 (be=0xF, id=3), then read 0x10 (id=5), with LATENCY=1. Required response: r_valid at cycle+1 with id=3 and r_data=0, then r_data=0xDEADBEEF with id=5.
REQ-025 Partial write test: after 0xDEADBEEF, write 0x00000011 at 0x10 with be=0x1, then read. Required response: 0xDEADBE11.
REQ-026 Throttle test: GNT_PERIOD=3 with req held high for 9 cycles. Required response: gnt in cycles 0, 3 and 6 only, and exactly 3 responses.
REQ-027 Latency/order test: LATENCY=4 with back-to-back reads of ids 1..6. Required response: r_valid for 6 consecutive cycles starting at cycle 4, with ids 1..6 in order.
REQ-028 Flush test: clear_i pulsed 2 cycles after 3 reads issued with LATENCY=4. Required response: no r_valid for those reads, and gnt=0 in the clear cycle.
REQ-029 Alias/reset test: write at 0x1000 with NB_WORDS=1024, DW=32, then read at 0x0. Required response: the written data. Then assert rst_ni mid-pipeline. Required response: r_valid=0 immediately.
